// File: rtl/vcve2_pkg.sv
// Shared types for the vcve2 mult/div path: operator encoding and element-sequencer states.
package vcve2_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      MDS_IDLE = 2'd0,
      MDS_RUN  = 2'd1,
      MDS_RESP = 2'd2
   } md_seq_state_e;

   function automatic logic md_op_is_mul(input md_op_e op);
      return (op == MD_OP_MULL) || (op == MD_OP_MULH);
   endfunction

endpackage

// File: rtl/vcve2_multdiv_elem_seq.sv
// Vector element sequencer in front of the mult/div unit; also holds its intermediate registers.
// VCVE2_MD_TAIL_AGNOSTIC_EN: tail elements become all-ones instead of copying the old destination.
//
// state    | meaning
// MDS_IDLE | waiting for a vector request, req_ready_o high
// MDS_RUN  | issuing element idx to mult/div, capturing each result
// MDS_RESP | result vector valid, held until consumer handshake
module vcve2_multdiv_elem_seq
   import vcve2_pkg::*;
#(
   parameter int NumElem = 4,
   parameter int IdxW    = $clog2(NumElem + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  md_op_e                req_op_i,
   input  logic [1:0]            req_signed_i,
   input  logic [IdxW-1:0]       req_vl_i,
   input  logic [32*NumElem-1:0] req_vs1_i,
   input  logic [32*NumElem-1:0] req_vs2_i,
   input  logic [32*NumElem-1:0] req_vd_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [32*NumElem-1:0] rsp_data_o,
   output logic                  md_mult_en_o,
   output logic                  md_div_en_o,
   output logic                  md_mult_sel_o,
   output logic                  md_div_sel_o,
   output md_op_e                md_operator_o,
   output logic [1:0]            md_signed_mode_o,
   output logic [31:0]           md_op_a_o,
   output logic [31:0]           md_op_b_o,
   output logic                  md_ready_o,
   input  logic [31:0]           md_result_i,
   input  logic                  md_valid_i,
   input  logic [33:0]           imd_val_d_i [2],
   input  logic [1:0]            imd_val_we_i,
   output logic [33:0]           imd_val_q_o [2]
);

   md_seq_state_e state_q, state_d;
   logic [IdxW-1:0] idx_q, vl_q;
   md_op_e          op_q;
   logic [1:0]      sgn_q;
   logic [31:0]     vs1_q [NumElem];
   logic [31:0]     vs2_q [NumElem];
   logic [31:0]     res_q [NumElem];
   logic [32*NumElem-1:0] tail_vec;
   logic run, accept, capture, last, is_mul;

`ifdef VCVE2_MD_TAIL_AGNOSTIC_EN
   assign tail_vec = '1;
`else
   assign tail_vec = req_vd_i;
`endif

   assign run     = (state_q == MDS_RUN);
   assign accept  = req_valid_i & req_ready_o;
   assign capture = run & md_valid_i;
   assign last    = (idx_q == vl_q - IdxW'(1));
   assign is_mul  = md_op_is_mul(op_q);

   assign req_ready_o      = (state_q == MDS_IDLE);
   assign rsp_valid_o      = (state_q == MDS_RESP);
   assign md_mult_en_o     = run & is_mul;
   assign md_mult_sel_o    = run & is_mul;
   assign md_div_en_o      = run & ~is_mul;
   assign md_div_sel_o     = run & ~is_mul;
   assign md_ready_o       = run;
   assign md_operator_o    = op_q;
   assign md_signed_mode_o = sgn_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         MDS_IDLE: if (req_valid_i) state_d = (req_vl_i == '0) ? MDS_RESP : MDS_RUN;
         MDS_RUN:  if (md_valid_i && last) state_d = MDS_RESP;
         MDS_RESP: if (rsp_ready_i) state_d = MDS_IDLE;
         default:  state_d = MDS_IDLE;
      endcase
   end

   always_comb begin
      md_op_a_o = '0;
      md_op_b_o = '0;
      for (int i = 0; i < NumElem; i++) begin
         if (run && idx_q == IdxW'(i)) begin
            md_op_a_o = vs1_q[i];
            md_op_b_o = vs2_q[i];
         end
      end
   end

   always_comb begin
      rsp_data_o = '0;
      for (int i = 0; i < NumElem; i++) rsp_data_o[32*i +: 32] = res_q[i];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= MDS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Tail value is preloaded into the whole buffer at accept; active elements overwrite it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q <= '0;
         vl_q  <= '0;
         op_q  <= MD_OP_MULL;
         sgn_q <= '0;
         for (int i = 0; i < NumElem; i++) begin
            vs1_q[i] <= '0;
            vs2_q[i] <= '0;
            res_q[i] <= '0;
         end
      end else if (accept) begin
         idx_q <= '0;
         vl_q  <= req_vl_i;
         op_q  <= req_op_i;
         sgn_q <= req_signed_i;
         for (int i = 0; i < NumElem; i++) begin
            vs1_q[i] <= req_vs1_i[32*i +: 32];
            vs2_q[i] <= req_vs2_i[32*i +: 32];
            res_q[i] <= tail_vec[32*i +: 32];
         end
      end else if (capture) begin
         idx_q <= idx_q + IdxW'(1);
         for (int i = 0; i < NumElem; i++) begin
            if (idx_q == IdxW'(i)) res_q[i] <= md_result_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         imd_val_q_o[0] <= '0;
         imd_val_q_o[1] <= '0;
      end else begin
         if (imd_val_we_i[0]) imd_val_q_o[0] <= imd_val_d_i[0];
         if (imd_val_we_i[1]) imd_val_q_o[1] <= imd_val_d_i[1];
      end
   end

endmodule

// File: tb/tb_vcve2_multdiv_elem_seq.sv
// Bench for vcve2_multdiv_elem_seq: emulated mult/div responder plus an arithmetic reference model.
module tb_vcve2_multdiv_elem_seq;
   import vcve2_pkg::*;

   localparam int NumElem = 4;
   localparam int IdxW    = $clog2(NumElem + 1);
   localparam int VW      = 32 * NumElem;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            req_valid_i = 1'b0;
   logic            req_ready_o;
   md_op_e          req_op_i = MD_OP_MULL;
   logic [1:0]      req_signed_i = '0;
   logic [IdxW-1:0] req_vl_i = '0;
   logic [VW-1:0]   req_vs1_i = '0, req_vs2_i = '0, req_vd_i = '0;
   logic            rsp_valid_o;
   logic            rsp_ready_i = 1'b0;
   logic [VW-1:0]   rsp_data_o;
   logic            md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
   md_op_e          md_operator_o;
   logic [1:0]      md_signed_mode_o;
   logic [31:0]     md_op_a_o, md_op_b_o;
   logic            md_ready_o;
   logic [31:0]     md_result_i;
   logic            md_valid_i, md_valid_resp, md_stray = 1'b0;
   logic [33:0]     imd_val_d_i [2];
   logic [1:0]      imd_val_we_i = '0;
   logic [33:0]     imd_val_q_o [2];

   int n_checks = 0, n_errors = 0;
   int lat_cnt = 1, accepted = 0, en_cycles = 0, bad_en = 0;
   logic [33:0] imd_model [2];

   assign md_valid_i = md_valid_resp | md_stray;

   vcve2_multdiv_elem_seq #(.NumElem(NumElem)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_signed_i(req_signed_i), .req_vl_i(req_vl_i), .req_vs1_i(req_vs1_i),
      .req_vs2_i(req_vs2_i), .req_vd_i(req_vd_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
      .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
      .md_mult_sel_o(md_mult_sel_o), .md_div_sel_o(md_div_sel_o),
      .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
      .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o), .md_ready_o(md_ready_o),
      .md_result_i(md_result_i), .md_valid_i(md_valid_i),
      .imd_val_d_i(imd_val_d_i), .imd_val_we_i(imd_val_we_i), .imd_val_q_o(imd_val_q_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] ref_elem(input md_op_e op, input logic [1:0] sgn,
                                            input logic [31:0] a, input logic [31:0] b);
      logic signed [32:0] ea, eb;
      logic signed [65:0] p;
      ea = {sgn[0] & a[31], a};
      eb = {sgn[1] & b[31], b};
      p  = 66'(ea) * 66'(eb);
      case (op)
         MD_OP_MULL: return p[31:0];
         MD_OP_MULH: return p[63:32];
         MD_OP_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (sgn == 2'b11) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
               return 32'($signed(a) / $signed(b));
            end
            return a / b;
         end
         default: begin
            if (b == 32'd0) return a;
            if (sgn == 2'b11) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
               return 32'($signed(a) % $signed(b));
            end
            return a % b;
         end
      endcase
   endfunction

   function automatic logic [31:0] tail_of(input logic [31:0] vd_elem);
`ifdef VCVE2_MD_TAIL_AGNOSTIC_EN
      return 32'hFFFF_FFFF;
`else
      return vd_elem;
`endif
   endfunction

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Emulated mult/div unit: random latency, one result per element.
   initial begin
      md_valid_resp = 1'b0;
      md_result_i   = '0;
      forever begin
         @(negedge clk_i);
         md_valid_resp = 1'b0;
         if (rst_ni && (md_mult_en_o || md_div_en_o)) begin
            if (lat_cnt == 0) begin
               md_result_i   = ref_elem(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
               md_valid_resp = 1'b1;
               lat_cnt       = $urandom_range(0, 3);
            end else begin
               lat_cnt--;
            end
         end
      end
   end

   always @(posedge clk_i) begin
      if (rst_ni) begin
         if (md_mult_en_o || md_div_en_o) en_cycles++;
         if (md_valid_i && md_ready_o) accepted++;
         if (md_mult_sel_o !== md_mult_en_o || md_div_sel_o !== md_div_en_o ||
             (md_mult_en_o && !(md_operator_o inside {MD_OP_MULL, MD_OP_MULH})) ||
             (md_div_en_o && !(md_operator_o inside {MD_OP_DIV, MD_OP_REM})) ||
             (md_ready_o !== (md_mult_en_o | md_div_en_o)))
            bad_en++;
      end
   end

   task automatic run_req(input string tag, input md_op_e op, input logic [1:0] sgn, input int vl,
                          input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic [VW-1:0] vd, input int hold);
      logic [VW-1:0] exp;
      int n;
      for (int i = 0; i < NumElem; i++)
         exp[32*i +: 32] = (i < vl) ? ref_elem(op, sgn, a[32*i +: 32], b[32*i +: 32])
                                    : tail_of(vd[32*i +: 32]);
      en_cycles = 0;
      accepted  = 0;
      n = 0;
      while (!req_ready_o && n < 100) begin @(negedge clk_i); n++; end
      check({tag, "_req_ready"}, 128'(req_ready_o), 128'(1));
      req_valid_i = 1'b1; req_op_i = op; req_signed_i = sgn; req_vl_i = IdxW'(vl);
      req_vs1_i = a; req_vs2_i = b; req_vd_i = vd;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      check({tag, "_operator"}, 128'({md_signed_mode_o, md_operator_o}), 128'({sgn, op}));
      n = 0;
      while (!rsp_valid_o && n < 200) begin @(negedge clk_i); n++; end
      check({tag, "_rsp_valid"}, 128'(rsp_valid_o), 128'(1));
      if (vl == 0) begin
         check({tag, "_vl0_latency"}, 128'(n), 128'(0));
         check({tag, "_vl0_no_en"}, 128'(en_cycles), 128'(0));
      end
      check({tag, "_data"}, 128'(rsp_data_o), 128'(exp));
      check({tag, "_valid_cnt"}, 128'(accepted), 128'(vl));
      for (int k = 0; k < hold; k++) begin
         md_stray = (k == 1);
         @(negedge clk_i);
         md_stray = 1'b0;
         if (k == hold - 1) begin
            check({tag, "_hold_data"}, 128'(rsp_data_o), 128'(exp));
            check({tag, "_hold_ready"}, 128'({rsp_valid_o, req_ready_o, md_ready_o}), 128'(3'b100));
         end
      end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      check({tag, "_after_hs"}, 128'({rsp_valid_o, req_ready_o}), 128'(2'b01));
   endtask

   task automatic rand_vec(output logic [VW-1:0] a, output logic [VW-1:0] b);
      for (int i = 0; i < NumElem; i++) begin
         a[32*i +: 32] = $urandom;
         b[32*i +: 32] = $urandom;
         case ($urandom_range(0, 7))
            0: b[32*i +: 32] = 32'd0;
            1: begin a[32*i +: 32] = 32'h8000_0000; b[32*i +: 32] = 32'hFFFF_FFFF; end
            2: b[32*i +: 32] = 32'($urandom_range(1, 9));
            default: ;
         endcase
      end
   endtask

   initial begin
      logic [VW-1:0] a, b, vd;
      int n;
      imd_val_d_i[0] = '0; imd_val_d_i[1] = '0;
      imd_model[0] = '0; imd_model[1] = '0;

      #2;
      check("rst_ctrl", 128'({req_ready_o, rsp_valid_o, md_mult_en_o, md_div_en_o,
                              md_mult_sel_o, md_div_sel_o, md_ready_o}), 128'(7'b1000000));
      check("rst_data", 128'(rsp_data_o), 128'(0));
      check("rst_imd", 128'({imd_val_q_o[1], imd_val_q_o[0]}), 128'(0));
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      for (int t = 0; t < 6; t++) begin
         imd_val_d_i[0] = {$urandom, 2'($urandom)};
         imd_val_d_i[1] = {$urandom, 2'($urandom)};
         imd_val_we_i   = (t == 0) ? 2'b11 : 2'($urandom);
         @(negedge clk_i);
         for (int k = 0; k < 2; k++) if (imd_val_we_i[k]) imd_model[k] = imd_val_d_i[k];
         imd_val_we_i = '0;
         check("imd", 128'({imd_val_q_o[1], imd_val_q_o[0]}), 128'({imd_model[1], imd_model[0]}));
      end

      run_req("mull", MD_OP_MULL, 2'b00, 4, {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd5}}, '0, 0);
      check("mull_fixed", 128'(rsp_data_o), 128'({32'd20, 32'd15, 32'd10, 32'd5}));
      run_req("div", MD_OP_DIV, 2'b11, 2, {64'd0, 32'hFFFF_FFF9, 32'd100},
              {64'd0, 32'd2, 32'd0}, {4{32'h5A5A_5A5A}}, 0);
      check("div_fixed", 128'(rsp_data_o[63:0]), 128'({32'hFFFF_FFFD, 32'hFFFF_FFFF}));
      rand_vec(a, b);
      run_req("rem_tail", MD_OP_REM, 2'b11, 2, a, b, {4{32'hA5A5_A5A5}}, 0);
      run_req("vl0", MD_OP_MULH, 2'b01, 0, a, b, {4{32'h1234_5678}}, 2);
      rand_vec(a, b);
      run_req("hold10", MD_OP_MULH, 2'b11, 3, a, b, {4{32'hC3C3_C3C3}}, 10);

      for (int r = 0; r < 10; r++) begin
         rand_vec(a, b);
         vd = {$urandom, $urandom, $urandom, $urandom};
         run_req("rand", md_op_e'($urandom_range(0, 3)), 2'($urandom), $urandom_range(0, NumElem),
                 a, b, vd, $urandom_range(0, 3));
      end

      // Reset while element 1 is in flight.
      a = {32'd44, 32'd33, 32'd22, 32'd11};
      b = {32'd7, 32'd6, 32'd5, 32'd4};
      req_valid_i = 1'b1; req_op_i = MD_OP_MULL; req_signed_i = 2'b00; req_vl_i = IdxW'(4);
      req_vs1_i = a; req_vs2_i = b; req_vd_i = '0;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      n = 0;
      while (!(md_mult_en_o && md_op_a_o == 32'd22) && n < 50) begin @(negedge clk_i); n++; end
      check("midrun_elem1", 128'({md_mult_en_o, md_op_a_o}), 128'({1'b1, 32'd22}));
      #1 rst_ni = 1'b0;
      #1;
      check("midrun_rst_ctrl", 128'({req_ready_o, rsp_valid_o, md_mult_en_o, md_div_en_o,
                                     md_mult_sel_o, md_div_sel_o, md_ready_o}), 128'(7'b1000000));
      check("midrun_rst_data", 128'(rsp_data_o), 128'(0));
      check("midrun_rst_imd", 128'({imd_val_q_o[1], imd_val_q_o[0]}), 128'(0));
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      run_req("post_rst", MD_OP_MULL, 2'b00, 4, a, b, '0, 1);

      check("enable_consistency", 128'(bad_en), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
